postproc_stream: RTL and testbench

//  Post-processing stage between the PE array accumulator output and the feature-map RAM write port.

---
 rtl/postproc_stream.sv | 221 ++++++++++++++++++++++
 tb/tb_postproc_stream.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/postproc_stream.sv
// Accumulator post-processing: per-pixel channel sum + bias, rounding requant with saturation,
// optional ReLU and 2x2/stride-2 max-pool, emitted as a valid/ready byte stream.
module postproc_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 26,
   parameter int BIAS_WIDTH = 16,
   parameter int MAX_CH     = 16,
   parameter int MAX_WIDTH  = 32,
   parameter int MAX_HEIGHT = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [$clog2(MAX_CH):0]           cfg_num_ch,
   input  logic [$clog2(MAX_WIDTH):0]        cfg_width,
   input  logic [$clog2(MAX_HEIGHT):0]       cfg_height,
   input  logic [4:0]                        cfg_shift,
   input  logic                              cfg_relu_en,
   input  logic                              cfg_pool_en,
   input  logic signed [BIAS_WIDTH-1:0]      cfg_bias,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic signed [ACC_WIDTH-1:0]       in_psum,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic signed [DATA_WIDTH-1:0]      out_data,
   output logic                              out_last,
   output logic                              busy,
   output logic                              done,
   output logic [1:0]                        dbg_state
);
   localparam int CHW    = $clog2(MAX_CH) + 1;
   localparam int WW     = $clog2(MAX_WIDTH) + 1;
   localparam int HW     = $clog2(MAX_HEIGHT) + 1;
   localparam int SUM_W  = ACC_WIDTH + $clog2(MAX_CH) + 1;
   localparam int PDEPTH = MAX_WIDTH / 2;
   localparam int PIW    = $clog2(PDEPTH);
   localparam logic signed [SUM_W:0] SAT_HI = (SUM_W+1)'((1 <<< (DATA_WIDTH-1)) - 1);
   localparam logic signed [SUM_W:0] SAT_LO = -SAT_HI - 1;

   // Handshake: a beat moves on either port only when valid && ready in the same cycle;
   // every stage freezes while out_valid is held against a low out_ready.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

   state_t                        state_q;
   logic                          done_q;
   logic [CHW-1:0]                num_ch_m1_q;
   logic [WW-1:0]                 w_q;
   logic [HW-1:0]                 h_q;
   logic [4:0]                    shift_q;
   logic                          relu_q, pool_q;
   logic signed [BIAS_WIDTH-1:0]  bias_q;

   logic [CHW-1:0]                ch_q;
   logic [WW-1:0]                 col_q;
   logic [HW-1:0]                 row_q;
   logic signed [SUM_W-1:0]       acc_q;

   logic                          s1_vld_q, s1_codd_q, s1_rodd_q, s1_last_q, s1_plast_q;
   logic [PIW-1:0]                s1_pidx_q;
   logic signed [SUM_W-1:0]       s1_sum_q;

   logic signed [DATA_WIDTH-1:0]  hold_q;
   logic signed [DATA_WIDTH-1:0]  pbuf_q [PDEPTH];
   logic [PDEPTH-1:0]             pbuf_vld_q;
   logic                          out_vld_q, out_last_q;
   logic signed [DATA_WIDTH-1:0]  out_data_q;

   logic                          stall, fire, last_ch, last_pix, pool_last_pix;
   logic signed [SUM_W-1:0]       psum_ext, acc_d, s1_sum_d;
   logic signed [SUM_W:0]         ext_sum, rnd, rnd_sum, shifted, sat;
   logic signed [DATA_WIDTH-1:0]  rq, pm, pool_out, out_data_d;
   logic                          emit_d, out_last_d;

   function automatic logic signed [DATA_WIDTH-1:0] smax(input logic signed [DATA_WIDTH-1:0] a,
                                                         input logic signed [DATA_WIDTH-1:0] b);
      return (a > b) ? a : b;
   endfunction

   assign stall     = out_vld_q && !out_ready;
   assign in_ready  = (state_q == S_RUN) && !stall;
   assign fire      = in_valid && in_ready;
   assign last_ch   = (ch_q == num_ch_m1_q);
   assign last_pix  = (col_q == w_q - WW'(1)) && (row_q == h_q - HW'(1));
   // Last pool window sits at the last even-aligned column/row pair; never matches when W<2 or H<2.
   assign pool_last_pix = (col_q == {w_q[WW-1:1], 1'b0} - WW'(1)) &&
                          (row_q == {h_q[HW-1:1], 1'b0} - HW'(1));
   assign psum_ext  = SUM_W'(in_psum);
   assign acc_d     = (ch_q == '0) ? psum_ext : acc_q + psum_ext;
   assign s1_sum_d  = acc_d + SUM_W'(bias_q);

   always_comb begin
      ext_sum = (SUM_W+1)'(s1_sum_q);
      rnd     = '0;
      if (shift_q != '0) rnd = (SUM_W+1)'(1) << (shift_q - 5'd1);
      rnd_sum = ext_sum + rnd;
      if (shift_q == '0)                shifted = ext_sum;
      else if (32'(shift_q) >= SUM_W)   shifted = ext_sum[SUM_W] ? '1 : '0;
      else                              shifted = rnd_sum >>> shift_q;
      if (shifted > SAT_HI)             sat = SAT_HI;
      else if (shifted < SAT_LO)        sat = SAT_LO;
      else                              sat = shifted;
      rq = sat[DATA_WIDTH-1:0];
      if (relu_q && rq[DATA_WIDTH-1]) rq = '0;
      pm         = s1_codd_q ? smax(hold_q, rq) : rq;
      pool_out   = smax(pm, pbuf_q[s1_pidx_q]);
      emit_d     = !pool_q || (s1_codd_q && s1_rodd_q && pbuf_vld_q[s1_pidx_q]);
      out_data_d = pool_q ? pool_out : rq;
      out_last_d = pool_q ? s1_plast_q : s1_last_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         done_q      <= 1'b0;
         num_ch_m1_q <= '0;
         w_q         <= '0;
         h_q         <= '0;
         shift_q     <= '0;
         relu_q      <= 1'b0;
         pool_q      <= 1'b0;
         bias_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (start) begin
               num_ch_m1_q <= (cfg_num_ch == '0) ? '0 : cfg_num_ch - CHW'(1);
               w_q         <= cfg_width;
               h_q         <= cfg_height;
               shift_q     <= cfg_shift;
               relu_q      <= cfg_relu_en;
               pool_q      <= cfg_pool_en;
               bias_q      <= cfg_bias;
               state_q     <= S_RUN;
            end
            S_RUN: if (fire && last_ch && last_pix) state_q <= S_FLUSH;
            S_FLUSH: if (!s1_vld_q && (!out_vld_q || out_ready)) begin
               state_q <= S_IDLE;
               done_q  <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_q       <= '0;
         col_q      <= '0;
         row_q      <= '0;
         acc_q      <= '0;
         s1_vld_q   <= 1'b0;
         s1_sum_q   <= '0;
         s1_codd_q  <= 1'b0;
         s1_rodd_q  <= 1'b0;
         s1_pidx_q  <= '0;
         s1_last_q  <= 1'b0;
         s1_plast_q <= 1'b0;
         hold_q     <= '0;
         pbuf_vld_q <= '0;
         for (int i = 0; i < PDEPTH; i++) pbuf_q[i] <= '0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE && start) begin
            ch_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            acc_q      <= '0;
            hold_q     <= '0;
            pbuf_vld_q <= '0;
         end
         if (fire) begin
            acc_q <= acc_d;
            if (last_ch) begin
               ch_q <= '0;
               if (col_q == w_q - WW'(1)) begin
                  col_q <= '0;
                  row_q <= row_q + HW'(1);
               end else begin
                  col_q <= col_q + WW'(1);
               end
            end else begin
               ch_q <= ch_q + CHW'(1);
            end
         end
         if (!stall) begin
            s1_vld_q <= fire && last_ch;
            if (fire && last_ch) begin
               s1_sum_q   <= s1_sum_d;
               s1_codd_q  <= col_q[0];
               s1_rodd_q  <= row_q[0];
               s1_pidx_q  <= col_q[PIW:1];
               s1_last_q  <= last_pix;
               s1_plast_q <= pool_last_pix;
            end
            out_vld_q  <= s1_vld_q && emit_d;
            out_last_q <= s1_vld_q && emit_d && out_last_d;
            if (s1_vld_q && emit_d) out_data_q <= out_data_d;
            // Even rows fold their horizontal max into the row buffer; odd rows read it back.
            if (s1_vld_q && pool_q) begin
               if (!s1_codd_q) begin
                  hold_q <= rq;
               end else if (!s1_rodd_q) begin
                  pbuf_q[s1_pidx_q]     <= pm;
                  pbuf_vld_q[s1_pidx_q] <= 1'b1;
               end
            end
         end
      end
   end

   assign out_valid = out_vld_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_postproc_stream.sv
// Bench for postproc_stream: directed vector table, backpressure and reset sequences,
// then random frames scored against a per-pixel arithmetic model.
module tb_postproc_stream;
   localparam int DW = 8;
   localparam int AW = 26;

   typedef struct {
      int ch; int w; int h; int shift; int relu; int pool; int bias;
   } cfg_t;

   typedef struct {
      string name;
      cfg_t  c;
      int    raster;
      int    np;
      int    ps[4];
      int    ne;
      int    ex[4];
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [4:0]      cfg_num_ch;
   logic [5:0]      cfg_width;
   logic [5:0]      cfg_height;
   logic [4:0]      cfg_shift;
   logic            cfg_relu_en;
   logic            cfg_pool_en;
   logic [15:0]     cfg_bias;
   logic            in_valid;
   logic            in_ready;
   logic [AW-1:0]   in_psum;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic            busy;
   logic            done;
   logic [1:0]      dbg_state;

   int              checks = 0;
   int              errors = 0;
   logic [DW-1:0]   exp_q[$];
   int              r_last_acc, r_first_ov, r_last_out, r_done;
   vec_t            tbl[8];

   always #5 clk = ~clk;

   postproc_stream dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_num_ch(cfg_num_ch), .cfg_width(cfg_width), .cfg_height(cfg_height),
      .cfg_shift(cfg_shift), .cfg_relu_en(cfg_relu_en), .cfg_pool_en(cfg_pool_en),
      .cfg_bias(cfg_bias), .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference: floor((sum + 2^(s-1)) / 2^s), clamp to int8, then ReLU.
   function automatic int requant(input longint s, input cfg_t c);
      longint r;
      if (c.shift == 0)       r = s;
      else if (c.shift >= 31) r = (s < 0) ? -1 : 0;
      else                    r = (s + (longint'(1) <<< (c.shift - 1))) >>> c.shift;
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      if (c.relu != 0 && r < 0) r = 0;
      return int'(r);
   endfunction

   task automatic build_expected(input cfg_t c, input int ps[$]);
      int img[32][32];
      int n, idx, m;
      n = (c.ch == 0) ? 1 : c.ch;
      idx = 0;
      exp_q.delete();
      for (int r = 0; r < c.h; r++) begin
         for (int k = 0; k < c.w; k++) begin
            longint s = c.bias;
            for (int j = 0; j < n; j++) s += ps[idx++];
            img[r][k] = requant(s, c);
         end
      end
      if (c.pool != 0) begin
         for (int pr = 0; pr < c.h / 2; pr++) begin
            for (int pc = 0; pc < c.w / 2; pc++) begin
               m = img[2*pr][2*pc];
               if (img[2*pr][2*pc+1] > m)   m = img[2*pr][2*pc+1];
               if (img[2*pr+1][2*pc] > m)   m = img[2*pr+1][2*pc];
               if (img[2*pr+1][2*pc+1] > m) m = img[2*pr+1][2*pc+1];
               exp_q.push_back(DW'(m));
            end
         end
      end else begin
         for (int r = 0; r < c.h; r++)
            for (int k = 0; k < c.w; k++) exp_q.push_back(DW'(img[r][k]));
      end
   endtask

   task automatic load_vec(input int i, output int ps[$]);
      ps.delete();
      exp_q.delete();
      if (tbl[i].raster != 0) begin
         for (int r = 0; r < tbl[i].c.h; r++)
            for (int k = 0; k < tbl[i].c.w; k++) ps.push_back((k < 4) ? r * 4 + k : 100);
      end else begin
         for (int j = 0; j < tbl[i].np; j++) ps.push_back(tbl[i].ps[j]);
      end
      for (int j = 0; j < tbl[i].ne; j++) exp_q.push_back(DW'(tbl[i].ex[j]));
   endtask

   // mode 0: out_ready always high; 1: random; 2: low for 3 cycles from the first out_valid.
   task automatic run_frame(input string nm, input cfg_t c, input int ps[$], input int mode, input int gap);
      logic [DW-1:0] got_d[$];
      logic          got_l[$];
      logic [DW-1:0] prev_d;
      logic          prev_l;
      bit            prev_stall;
      int            idx, cyc, done_cnt, post, low_cnt;
      idx = 0; cyc = 0; done_cnt = 0; post = 0; low_cnt = 0; prev_stall = 0;
      prev_d = '0; prev_l = 1'b0;
      r_last_acc = -1; r_first_ov = -1; r_last_out = -1; r_done = -1;
      @(negedge clk);
      cfg_num_ch = 5'(c.ch); cfg_width = 6'(c.w); cfg_height = 6'(c.h);
      cfg_shift = 5'(c.shift); cfg_relu_en = 1'(c.relu); cfg_pool_en = 1'(c.pool);
      cfg_bias = 16'(c.bias); start = 1'b1;
      while (cyc < 3000 && post < 3) begin
         @(negedge clk);
         start = 1'b0;
         if (out_valid && r_first_ov < 0) r_first_ov = cyc;
         if (prev_stall) begin
            chk({nm, " hold_valid"}, out_valid, 1);
            chk({nm, " hold_data"}, out_data, prev_d);
            chk({nm, " hold_last"}, out_last, prev_l);
         end
         if (idx < ps.size() && $urandom_range(0, 99) >= gap) begin
            in_valid = 1'b1;
            in_psum  = AW'(ps[idx]);
         end else begin
            in_valid = 1'b0;
            in_psum  = AW'($urandom);
         end
         case (mode)
            1: out_ready = ($urandom_range(0, 99) < 65);
            2: if (r_first_ov >= 0 && low_cnt < 3) begin
                  out_ready = 1'b0;
                  low_cnt++;
               end else begin
                  out_ready = 1'b1;
               end
            default: out_ready = 1'b1;
         endcase
         #1;
         prev_stall = out_valid && !out_ready;
         if (prev_stall) begin
            chk({nm, " stall_in_ready"}, in_ready, 0);
            prev_d = out_data;
            prev_l = out_last;
         end
         if (in_valid && in_ready) begin
            idx++;
            r_last_acc = cyc;
         end
         if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
            r_last_out = cyc;
         end
         if (done) begin
            done_cnt++;
            r_done = cyc;
         end
         if (done_cnt > 0) post++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk({nm, " beats_in"}, idx, ps.size());
      chk({nm, " done_pulses"}, done_cnt, 1);
      chk({nm, " busy_after"}, busy, 0);
      chk({nm, " n_out"}, got_d.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
         chk($sformatf("%s data[%0d]", nm, i), longint'($signed(got_d[i])), longint'($signed(exp_q[i])));
         chk($sformatf("%s last[%0d]", nm, i), got_l[i], (i == exp_q.size() - 1) ? 1 : 0);
      end
   endtask

   initial begin
      int   ps[$];
      cfg_t c;
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_psum = '0; out_ready = 1'b1;
      cfg_num_ch = '0; cfg_width = '0; cfg_height = '0; cfg_shift = '0;
      cfg_relu_en = 1'b0; cfg_pool_en = 1'b0; cfg_bias = '0;

      tbl[0] = '{"t1_basic",   '{1, 2, 2, 0, 0, 0, 0},   0, 4, '{1, 2, 3, 4},          4, '{1, 2, 3, 4}};
      tbl[1] = '{"t2_bias_pos",'{3, 1, 1, 2, 0, 0, 10},  0, 3, '{5, 6, 7, 0},          1, '{7, 0, 0, 0}};
      tbl[2] = '{"t2_bias_neg",'{3, 1, 1, 2, 0, 0, -10}, 0, 3, '{-5, -6, -7, 0},       1, '{-7, 0, 0, 0}};
      tbl[3] = '{"t3_sat_hi",  '{1, 1, 1, 0, 0, 0, 0},   0, 1, '{100000, 0, 0, 0},     1, '{127, 0, 0, 0}};
      tbl[4] = '{"t3_sat_lo",  '{1, 1, 1, 0, 0, 0, 0},   0, 1, '{-100000, 0, 0, 0},    1, '{-128, 0, 0, 0}};
      tbl[5] = '{"t3_relu",    '{1, 1, 1, 0, 1, 0, 0},   0, 1, '{-100000, 0, 0, 0},    1, '{0, 0, 0, 0}};
      tbl[6] = '{"t4_pool4x4", '{1, 4, 4, 0, 0, 1, 0},   1, 0, '{0, 0, 0, 0},          4, '{5, 7, 13, 15}};
      tbl[7] = '{"t4_pool5x4", '{1, 5, 4, 0, 0, 1, 0},   1, 0, '{0, 0, 0, 0},          4, '{5, 7, 13, 15}};

      repeat (3) @(negedge clk);
      #1;
      chk("reset in_ready", in_ready, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_data", out_data, 0);
      chk("reset out_last", out_last, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset state", dbg_state, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         load_vec(i, ps);
         run_frame(tbl[i].name, tbl[i].c, ps, 0, 0);
         if (i == 0) chk("t1 done_after_last", r_done - r_last_out, 1);
         if (i == 1) chk("t2 latency", r_first_ov - r_last_acc, 2);
      end

      load_vec(0, ps);
      run_frame("t5_backpressure", tbl[0].c, ps, 2, 0);

      // Abort a frame after two beats, then the same frame must run cleanly.
      @(negedge clk);
      cfg_num_ch = 5'd1; cfg_width = 6'd2; cfg_height = 6'd2; cfg_shift = '0;
      cfg_relu_en = 1'b0; cfg_pool_en = 1'b0; cfg_bias = '0; start = 1'b1;
      @(negedge clk); start = 1'b0; in_valid = 1'b1; in_psum = AW'(1);
      @(negedge clk); in_psum = AW'(2);
      @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
      #1;
      chk("t6 in_ready", in_ready, 0);
      chk("t6 out_valid", out_valid, 0);
      chk("t6 out_data", out_data, 0);
      chk("t6 out_last", out_last, 0);
      chk("t6 busy", busy, 0);
      chk("t6 done", done, 0);
      chk("t6 state", dbg_state, 0);
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("t6 no_done_after_reset", done, 0);
      load_vec(0, ps);
      run_frame("t6_rerun", tbl[0].c, ps, 0, 0);

      for (int k = 0; k < 14; k++) begin
         int scale;
         c.ch    = $urandom_range(0, 4);
         c.w     = $urandom_range(1, 6);
         c.h     = $urandom_range(1, 6);
         c.shift = ($urandom_range(0, 5) == 0) ? $urandom_range(28, 31) : $urandom_range(0, 12);
         c.relu  = $urandom_range(0, 1);
         c.pool  = $urandom_range(0, 1);
         c.bias  = int'($signed(16'($urandom)));
         scale   = $urandom_range(0, 2);
         ps.delete();
         for (int j = 0; j < c.w * c.h * ((c.ch == 0) ? 1 : c.ch); j++) begin
            case (scale)
               0:       ps.push_back($urandom_range(0, 400) - 200);
               1:       ps.push_back($urandom_range(0, 200000) - 100000);
               default: ps.push_back(int'($signed($urandom)) >>> 6);
            endcase
         end
         build_expected(c, ps);
         run_frame($sformatf("rnd%0d", k), c, ps, 1, 30);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
